// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus slot map, default sizes and transfer FSM encoding
package bus_pkg;

  localparam int BUS_DATA_W  = 16;
  localparam int BUS_NUM_SRC = 16;

  // Source slot map; slot 0 means "nobody drives the bus".
  localparam int SLOT_IDLE = 0;
  localparam int SLOT_PC   = 1;
  localparam int SLOT_DAR  = 2;
  localparam int SLOT_IR   = 4;
  localparam int SLOT_AC   = 5;
  localparam int SLOT_R    = 6;
  localparam int SLOT_R1   = 7;
  localparam int SLOT_R2   = 8;
  localparam int SLOT_R3   = 9;
  localparam int SLOT_R4   = 10;
  localparam int SLOT_R5   = 11;
  localparam int SLOT_DM   = 12;
  localparam int SLOT_IM   = 13;

  typedef enum logic [0:0] {
    BUS_IDLE  = 1'b0,
    BUS_VALID = 1'b1
  } bus_state_e;

endpackage

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - combinational round-robin pick over slots 1..NUM_SRC-1
//   src_req   in   NUM_SRC  request per slot, bit 0 never granted
//   ptr       in   SEL_W    last granted slot; search starts just after it
//   grant     out  NUM_SRC  one-hot winner, 0 when nobody requests
//   grant_idx out  SEL_W    winner index
//   grant_vld out  1        a winner exists
module bus_rr_arbiter #(
  parameter int NUM_SRC = 16,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   grant_idx,
  output logic               grant_vld
);

  // Priority order, highest first: ptr+1 .. NUM_SRC-1, then 1 .. ptr.
  // Slot 0 is outside the ring, so the modulus is NUM_SRC-1.
  logic [SEL_W-1:0] scan_idx [NUM_SRC];

  assign scan_idx[0] = '0;
  for (genvar g = 1; g < NUM_SRC; g++) begin : g_scan
    assign scan_idx[g] = SEL_W'(((int'(ptr) + g - 1) % (NUM_SRC - 1)) + 1);
  end

  logic unused_req0;
  assign unused_req0 = src_req[0];

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (!grant_vld && src_req[scan_idx[i]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[i];
      end
    end
  end

  assign grant = grant_vld ? (NUM_SRC'(1) << grant_idx) : '0;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - registered bus source mux with direct/round-robin select and valid/ready output
//   clock/reset_n  rising-edge clock, asynchronous active-low reset
//   mode           0 = direct select by read_en, 1 = round-robin over src_req
//   read_en        direct source index, 0 or >= NUM_SRC means idle
//   src_req        round-robin requests, bit 0 ignored
//   src_data       flattened sources, slot k at [k*DATA_W +: DATA_W]
//   out_ready      consumer takes busout this cycle
//   busout         registered bus value
//   bus_valid      busout holds an unconsumed transfer
//   bus_src        slot that produced busout
//   bus_parity     even parity of busout (only when BUS_PARITY_EN is defined)
//   grant          one-hot slot being loaded this cycle, combinational
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter  int DATA_W  = BUS_DATA_W,
  parameter  int NUM_SRC = BUS_NUM_SRC,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          read_en,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         busout,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_src,
`ifdef BUS_PARITY_EN
  output logic                      bus_parity,
`endif
  output logic [NUM_SRC-1:0]        grant
);

  localparam logic [0:0] IDLE  = BUS_IDLE;
  localparam logic [0:0] VALID = BUS_VALID;

  logic [0:0]         state;
  logic [SEL_W-1:0]   ptr;

  logic [NUM_SRC-1:0] rr_grant;
  logic [SEL_W-1:0]   rr_idx;
  logic               rr_vld;

  logic               dir_ok;
  logic [NUM_SRC-1:0] dir_grant;
  logic               cand_vld;
  logic [SEL_W-1:0]   cand_idx;
  logic               can_take;
  logic               load;
  logic [DATA_W-1:0]  sel_word;

  bus_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_arb (
    .src_req   (src_req),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  assign dir_ok    = (read_en != '0) && (int'(read_en) < NUM_SRC);
  assign dir_grant = NUM_SRC'(1) << read_en;

  assign cand_vld = mode ? rr_vld : dir_ok;
  assign cand_idx = mode ? rr_idx : read_en;

  // A held transfer blocks new loads until the consumer takes it.
  // reset_n is folded in so grant reads 0 while reset is asserted.
  assign can_take = (state == IDLE) || out_ready;
  assign load     = reset_n && can_take && cand_vld;

  assign grant     = load ? (mode ? rr_grant : dir_grant) : '0;
  assign bus_valid = (state == VALID);
  assign sel_word  = src_data[int'(cand_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busout  <= '0;
      bus_src <= '0;
      ptr     <= '0;
    end else begin
      if (load) begin
        state   <= VALID;
        busout  <= sel_word;
        bus_src <= cand_idx;
        if (mode) begin
          ptr <= rr_idx;
        end
      end else if (out_ready) begin
        // Consumed with nothing to follow: data stays visible, valid drops.
        state <= IDLE;
      end
    end
  end

`ifdef BUS_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_parity <= 1'b0;
    end else if (load) begin
      bus_parity <= ^sel_word;
    end
  end
`endif

endmodule
